// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the single-port unified memory between the core and the
// debug/program loader, sequencing each access as issue, latency wait and acknowledge.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWData,
  output logic [DATA_W-1:0] oCpuRData,
  output logic              oCpuAck,
  input  logic              iDbgReq,
  input  logic              iDbgWe,
  input  logic [ADDR_W-1:0] iDbgAddr,
  input  logic [DATA_W-1:0] iDbgWData,
  output logic [DATA_W-1:0] oDbgRData,
  output logic              oDbgAck,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oMemWe,
  output logic              oMemRe,
  input  logic [DATA_W-1:0] iMemRData,
  output logic [1:0]        oGrant
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wData_q, wData_d;
  logic [2:0]        lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] cpuRData_q, cpuRData_d;
  logic [DATA_W-1:0] dbgRData_q, dbgRData_d;
  logic              dbgWins;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wData_q    <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      cpuRData_q <= '0;
      dbgRData_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wData_q    <= wData_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      cpuRData_q <= cpuRData_d;
      dbgRData_q <= dbgRData_d;
    end
  end

  // Debug wins when it is alone, or when the CPU has starved it long enough.
  assign dbgWins = iDbgReq && (!iCpuReq || (starve_q == SW'(STARVE_MAX)));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wData_d    = wData_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    cpuRData_d = cpuRData_q;
    dbgRData_d = dbgRData_q;
    oMemWe     = 1'b0;
    oMemRe     = 1'b0;
    oCpuAck    = 1'b0;
    oDbgAck    = 1'b0;

    case (state_q)
      IDLE: begin
        if (iCpuReq || iDbgReq) begin
          state_d = ISSUE;
          if (dbgWins) begin
            owner_d  = OWN_DBG;
            we_d     = iDbgWe;
            addr_d   = iDbgAddr;
            wData_d  = iDbgWData;
            starve_d = '0;
          end else begin
            owner_d = OWN_CPU;
            we_d    = iCpuWe;
            addr_d  = iCpuAddr;
            wData_d = iCpuWData;
            if (iDbgReq && (starve_q != SW'(STARVE_MAX)))
              starve_d = starve_q + SW'(1);
          end
        end
      end
      ISSUE: begin
        oMemWe  = we_q;
        oMemRe  = !we_q;
        lat_d   = 3'(MEM_LAT);
        state_d = we_q ? ACK : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          if (owner_q == OWN_CPU) cpuRData_d = iMemRData;
          if (owner_q == OWN_DBG) dbgRData_d = iMemRData;
          state_d = ACK;
        end
      end
      ACK: begin
        oCpuAck = (owner_q == OWN_CPU);
        oDbgAck = (owner_q == OWN_DBG);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oGrant    = (state_q == IDLE) ? OWN_NONE : owner_q;
  assign oMemAddr  = addr_q;
  assign oMemWData = wData_q;
  assign oCpuRData = cpuRData_q;
  assign oDbgRData = dbgRData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at
// MEM_LAT=4, sharing request stimulus, each with its own memory latency model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpuReq, cpuWe, dbgReq, dbgWe;
  logic [31:0] cpuAddr, cpuWData, dbgAddr, dbgWData;

  logic [31:0] c1RData, d1RData, m1Addr, m1WData, m1RData;
  logic        c1Ack, d1Ack, m1We, m1Re;
  logic [1:0]  g1;

  logic [31:0] c4RData, d4RData, m4Addr, m4WData, m4RData;
  logic        c4Ack, d4Ack, m4We, m4Re;
  logic [1:0]  g4;

  logic [31:0] pipe1;
  logic [31:0] pipe4 [4];

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(8)) dut1 (
    .iClk(clk), .iRst(rst),
    .iCpuReq(cpuReq), .iCpuWe(cpuWe), .iCpuAddr(cpuAddr), .iCpuWData(cpuWData),
    .oCpuRData(c1RData), .oCpuAck(c1Ack),
    .iDbgReq(dbgReq), .iDbgWe(dbgWe), .iDbgAddr(dbgAddr), .iDbgWData(dbgWData),
    .oDbgRData(d1RData), .oDbgAck(d1Ack),
    .oMemAddr(m1Addr), .oMemWData(m1WData), .oMemWe(m1We), .oMemRe(m1Re),
    .iMemRData(m1RData), .oGrant(g1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .STARVE_MAX(8)) dut4 (
    .iClk(clk), .iRst(rst),
    .iCpuReq(cpuReq), .iCpuWe(cpuWe), .iCpuAddr(cpuAddr), .iCpuWData(cpuWData),
    .oCpuRData(c4RData), .oCpuAck(c4Ack),
    .iDbgReq(dbgReq), .iDbgWe(dbgWe), .iDbgAddr(dbgAddr), .iDbgWData(dbgWData),
    .oDbgRData(d4RData), .oDbgAck(d4Ack),
    .oMemAddr(m4Addr), .oMemWData(m4WData), .oMemWe(m4We), .oMemRe(m4Re),
    .iMemRData(m4RData), .oGrant(g4)
  );

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory models: data is valid only MEM_LAT cycles after the read strobe.
  always @(posedge clk) begin
    pipe1 <= m1Re ? memVal(m1Addr) : 32'hBAD0_0001;
    pipe4[0] <= m4Re ? memVal(m4Addr) : 32'hBAD0_0004;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign m1RData = pipe1;
  assign m4RData = pipe4[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWData = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (g1 !== 2'b00) begin failures++; $display("FAIL rst_grant got=%h exp=%h", g1, 2'b00); end
    checks++; if ({c1Ack, d1Ack, m1We, m1Re} !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=%b", {c1Ack, d1Ack, m1We, m1Re}, 4'b0); end
    checks++; if (m1Addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=%h", m1Addr, 32'h0); end
    checks++; if (m1WData !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=%h", m1WData, 32'h0); end
    checks++; if ({c1RData, d1RData} !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=%h", {c1RData, d1RData}, 64'h0); end
    checks++; if ({g4, c4Ack, d4Ack, m4We, m4Re} !== 6'b0) begin failures++; $display("FAIL rst_lat4 got=%b exp=%b", {g4, c4Ack, d4Ack, m4We, m4Re}, 6'b0); end
  endtask

  task automatic test_cpu_read();
    doReset();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h40;
    checks++; if (g1 !== 2'b00) begin failures++; $display("FAIL rd_idle_grant got=%h exp=%h", g1, 2'b00); end
    tick();
    checks++; if ({m1Re, m1We} !== 2'b10) begin failures++; $display("FAIL rd_strobe got=%b exp=%b", {m1Re, m1We}, 2'b10); end
    checks++; if (m1Addr !== 32'h40) begin failures++; $display("FAIL rd_addr got=%h exp=%h", m1Addr, 32'h40); end
    checks++; if (g1 !== 2'b01) begin failures++; $display("FAIL rd_grant_t1 got=%h exp=%h", g1, 2'b01); end
    tick();
    checks++; if ({c1Ack, m1Re, g1} !== 4'b0001) begin failures++; $display("FAIL rd_wait got=%b exp=%b", {c1Ack, m1Re, g1}, 4'b0001); end
    tick();
    checks++; if ({c1Ack, d1Ack} !== 2'b10) begin failures++; $display("FAIL rd_ack got=%b exp=%b", {c1Ack, d1Ack}, 2'b10); end
    checks++; if (c1RData !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=%h", c1RData, 32'hDEADBEEF); end
    checks++; if (g1 !== 2'b01) begin failures++; $display("FAIL rd_grant_t3 got=%h exp=%h", g1, 2'b01); end
    checks++; if (d1RData !== 32'h0) begin failures++; $display("FAIL rd_dbg_untouched got=%h exp=%h", d1RData, 32'h0); end
    tick();
    cpuReq = 1'b0;
    checks++; if ({c1Ack, g1} !== 3'b000) begin failures++; $display("FAIL rd_after got=%b exp=%b", {c1Ack, g1}, 3'b000); end
    checks++; if (c1RData !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h exp=%h", c1RData, 32'hDEADBEEF); end
  endtask

  task automatic test_cpu_write();
    doReset();
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h80; cpuWData = 32'h12345678;
    tick();
    checks++; if ({m1We, m1Re} !== 2'b10) begin failures++; $display("FAIL wr_strobe got=%b exp=%b", {m1We, m1Re}, 2'b10); end
    checks++; if (m1Addr !== 32'h80) begin failures++; $display("FAIL wr_addr got=%h exp=%h", m1Addr, 32'h80); end
    checks++; if (m1WData !== 32'h12345678) begin failures++; $display("FAIL wr_wdata got=%h exp=%h", m1WData, 32'h12345678); end
    checks++; if (g1 !== 2'b01) begin failures++; $display("FAIL wr_grant got=%h exp=%h", g1, 2'b01); end
    tick();
    checks++; if ({c1Ack, d1Ack, m1We} !== 3'b100) begin failures++; $display("FAIL wr_ack got=%b exp=%b", {c1Ack, d1Ack, m1We}, 3'b100); end
    tick();
    cpuReq = 1'b0;
    checks++; if ({c1Ack, d1Ack, g1} !== 4'b0000) begin failures++; $display("FAIL wr_idle got=%b exp=%b", {c1Ack, d1Ack, g1}, 4'b0000); end
    checks++; if (m1Addr !== 32'h80) begin failures++; $display("FAIL wr_addr_hold got=%h exp=%h", m1Addr, 32'h80); end
    checks++; if (c1RData !== 32'h0) begin failures++; $display("FAIL wr_no_capture got=%h exp=%h", c1RData, 32'h0); end
  endtask

  // Three CPU-only grants first (must not advance the starvation count), then both requesting.
  task automatic test_starvation();
    logic [1:0] expOwn;
    logic [31:0] expAddr;
    doReset();
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h100; cpuWData = 32'hC0C0_0000;
    dbgWe = 1'b1; dbgAddr = 32'h200; dbgWData = 32'hDB00_0000;
    for (int g = 0; g < 21; g++) begin
      if (g < 3) expOwn = 2'b01;
      else expOwn = (((g - 3) % 9) == 8) ? 2'b10 : 2'b01;
      expAddr = (expOwn == 2'b10) ? 32'h200 : 32'h100;
      tick();
      checks++; if (g1 !== expOwn) begin failures++; $display("FAIL starve_grant%0d got=%h exp=%h", g, g1, expOwn); end
      checks++; if ({m1We, m1Re, m1Addr} !== {2'b10, expAddr}) begin failures++; $display("FAIL starve_issue%0d got=%h exp=%h", g, {m1We, m1Re, m1Addr}, {2'b10, expAddr}); end
      tick();
      checks++; if ({c1Ack, d1Ack, m1We, m1Re} !== {expOwn == 2'b01, expOwn == 2'b10, 2'b00}) begin failures++; $display("FAIL starve_ack%0d got=%b exp=%b", g, {c1Ack, d1Ack, m1We, m1Re}, {expOwn == 2'b01, expOwn == 2'b10, 2'b00}); end
      tick();
      checks++; if ({g1, m1We, m1Re} !== 4'b0000) begin failures++; $display("FAIL starve_idle%0d got=%b exp=%b", g, {g1, m1We, m1Re}, 4'b0000); end
      if (g == 2) dbgReq = 1'b1;
    end
    cpuReq = 1'b0; dbgReq = 1'b0;
  endtask

  task automatic test_dbg_read_lat4();
    doReset();
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h300;
    tick();
    checks++; if ({m4Re, m4We, g4} !== 4'b1010) begin failures++; $display("FAIL l4_issue got=%b exp=%b", {m4Re, m4We, g4}, 4'b1010); end
    checks++; if (m4Addr !== 32'h300) begin failures++; $display("FAIL l4_addr got=%h exp=%h", m4Addr, 32'h300); end
    tick();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h40;
    for (int c = 2; c <= 5; c++) begin
      checks++; if ({d4Ack, c4Ack, g4} !== 4'b0010) begin failures++; $display("FAIL l4_wait%0d got=%b exp=%b", c, {d4Ack, c4Ack, g4}, 4'b0010); end
      tick();
    end
    checks++; if ({d4Ack, c4Ack} !== 2'b10) begin failures++; $display("FAIL l4_ack got=%b exp=%b", {d4Ack, c4Ack}, 2'b10); end
    checks++; if (d4RData !== memVal(32'h300)) begin failures++; $display("FAIL l4_data got=%h exp=%h", d4RData, memVal(32'h300)); end
    checks++; if (c4RData !== 32'h0) begin failures++; $display("FAIL l4_cpu_untouched got=%h exp=%h", c4RData, 32'h0); end
    tick();
    dbgReq = 1'b0;
    checks++; if (g4 !== 2'b00) begin failures++; $display("FAIL l4_idle got=%h exp=%h", g4, 2'b00); end
    tick();
    checks++; if ({g4, m4Re, m4Addr} !== {2'b01, 1'b1, 32'h40}) begin failures++; $display("FAIL l4_cpu_issue got=%h exp=%h", {g4, m4Re, m4Addr}, {2'b01, 1'b1, 32'h40}); end
    for (int c = 0; c < 5; c++) tick();
    checks++; if ({c4Ack, c4RData} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL l4_cpu_ack got=%h exp=%h", {c4Ack, c4RData}, {1'b1, 32'hDEADBEEF}); end
    checks++; if (d4RData !== memVal(32'h300)) begin failures++; $display("FAIL l4_dbg_hold got=%h exp=%h", d4RData, memVal(32'h300)); end
    tick();
    cpuReq = 1'b0;
  endtask

  task automatic test_reset_mid();
    doReset();
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h40;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({c1Ack, d1Ack, m1We, m1Re, g1} !== 6'b0) begin failures++; $display("FAIL mid_ctrl got=%b exp=%b", {c1Ack, d1Ack, m1We, m1Re, g1}, 6'b0); end
    checks++; if ({m1Addr, c1RData} !== 64'h0) begin failures++; $display("FAIL mid_data got=%h exp=%h", {m1Addr, c1RData}, 64'h0); end
    tick();
    checks++; if ({m1Re, g1, m1Addr} !== {1'b1, 2'b01, 32'h40}) begin failures++; $display("FAIL mid_reissue got=%h exp=%h", {m1Re, g1, m1Addr}, {1'b1, 2'b01, 32'h40}); end
    tick();
    checks++; if (c1Ack !== 1'b0) begin failures++; $display("FAIL mid_wait_ack got=%b exp=%b", c1Ack, 1'b0); end
    tick();
    checks++; if ({c1Ack, c1RData} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL mid_done got=%h exp=%h", {c1Ack, c1RData}, {1'b1, 32'hDEADBEEF}); end
    tick();
    cpuReq = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
    doReset();
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = addrs[0]; dbgWData = 32'hA000_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({g1, m1We, m1Re} !== 4'b1010) begin failures++; $display("FAIL b2b_issue%0d got=%b exp=%b", k, {g1, m1We, m1Re}, 4'b1010); end
      checks++; if ({m1Addr, m1WData} !== {addrs[k], 32'hA000_0000 + 32'(k)}) begin failures++; $display("FAIL b2b_fields%0d got=%h exp=%h", k, {m1Addr, m1WData}, {addrs[k], 32'hA000_0000 + 32'(k)}); end
      tick();
      checks++; if ({d1Ack, c1Ack} !== 2'b10) begin failures++; $display("FAIL b2b_ack%0d got=%b exp=%b", k, {d1Ack, c1Ack}, 2'b10); end
      tick();
      checks++; if (g1 !== 2'b00) begin failures++; $display("FAIL b2b_idle%0d got=%h exp=%h", k, g1, 2'b00); end
      if (k < 2) begin
        dbgAddr = addrs[k+1];
        dbgWData = 32'hA000_0000 + 32'(k + 1);
      end else begin
        dbgReq = 1'b0;
      end
    end
    tick();
    checks++; if ({g1, m1We, m1Re} !== 4'b0000) begin failures++; $display("FAIL b2b_quiet got=%b exp=%b", {g1, m1We, m1Re}, 4'b0000); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starvation();
    test_dbg_read_lat4();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
